// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed seven-segment scanner with per-digit registers, enable mask, PWM brightness and blanking
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 64,
  parameter int BRIGHT_BITS  = 4,
  localparam int AW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [8:0]             i_wr_data,
  input  logic                   i_enable,
  input  logic [NUM_DIGITS-1:0]  i_digit_en,
  input  logic [BRIGHT_BITS-1:0] i_brightness,
  output logic [NUM_DIGITS-1:0]  o_an,
  output logic [6:0]             o_seg,
  output logic                   o_dp,
  output logic                   o_frame
);
  localparam int SLOT_CYCLES = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int SW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  if (SLOT_CYCLES <= BLANK_CYCLES) begin : g_bad_timing
    $error("sevenseg_scan_ctrl: slot length %0d must exceed BLANK_CYCLES %0d", SLOT_CYCLES, BLANK_CYCLES);
  end

  logic [8:0]             r_digit [NUM_DIGITS];
  logic [SW-1:0]          r_slot_cnt;
  logic [AW-1:0]          r_digit_idx;
  logic [BRIGHT_BITS-1:0] r_pwm_cnt;
  logic [NUM_DIGITS-1:0]  r_an;
  logic [6:0]             r_seg;
  logic                   r_dp;
  logic                   r_frame;
  logic                   w_slot_wrap;
  logic                   w_frame_wrap;
  logic                   w_on;
  logic [8:0]             w_cur;
  logic [6:0]             w_seg;

  assign w_slot_wrap  = int'(r_slot_cnt) == SLOT_CYCLES - 1;
  assign w_frame_wrap = w_slot_wrap && int'(r_digit_idx) == NUM_DIGITS - 1;
  assign w_cur        = r_digit[r_digit_idx];
  assign w_on         = i_enable && i_digit_en[r_digit_idx] &&
                        int'(r_slot_cnt) >= BLANK_CYCLES && r_pwm_cnt <= i_brightness;
  // raw bits are {dp,g,f,e,d,c,b,a}; the segment bus is ordered a..g MSB first
  assign w_seg = w_cur[8] ? ~{w_cur[0], w_cur[1], w_cur[2], w_cur[3], w_cur[4], w_cur[5], w_cur[6]}
                          : HEX[w_cur[3:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 9'h100;
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
      r_pwm_cnt   <= '0;
      r_an        <= '1;
      r_seg       <= 7'h7F;
      r_dp        <= 1'b1;
      r_frame     <= 1'b0;
    end else begin
      if (i_wr_en && int'(i_wr_addr) < NUM_DIGITS) r_digit[i_wr_addr] <= i_wr_data;
      r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
      if (w_slot_wrap) r_digit_idx <= w_frame_wrap ? '0 : r_digit_idx + 1'b1;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_an      <= w_on ? ~(NUM_DIGITS'(1) << r_digit_idx) : '1;
      r_seg     <= w_on ? w_seg : 7'h7F;
      r_dp      <= w_on ? ~w_cur[7] : 1'b1;
      r_frame   <= w_frame_wrap;
    end
  end

  assign o_an    = r_an;
  assign o_seg   = r_seg;
  assign o_dp    = r_dp;
  assign o_frame = r_frame;
endmodule
